usb_tx_sched: RTL and testbench
===============================

USB_TX_SCHED -- requirements
Module: usb_tx_sched

Interface
REQ-001 Parameter IPG_CLKS, default 16, inter-packet gap in clk_48 cycles after usb_tx_en falls before the next packet may start (range 1..255).
REQ-002 clk_48  in  1  48 MHz clock; reset rst_n, asynchronous, active-low; clock clk_48.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 hs_req  in  1  handshake request, level, held until hs_done.
REQ-005 hs_pid  in  2  handshake select: 0 ACK, 1 NAK, 2 STALL, 3 reserved (sent as STALL).
REQ-006 hs_done  out  1  one-cycle pulse: handshake packet fully sent.
REQ-007 dat_req  in  1  data packet request, level, held until dat_done.
REQ-008 dat_toggle  in  1  0 DATA0, 1 DATA1; sampled at grant.
REQ-009 dat_zlp  in  1  zero-length packet; sampled at grant.
REQ-010 dat_valid / dat_data / dat_last  in  1/8/1  payload byte stream.
REQ-011 dat_ready  out  1  one-cycle pulse: current payload byte consumed.
REQ-012 dat_done  out  1  one-cycle pulse: data packet fully sent (EOP complete).
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 tx_transmit / tx_data / tx_update_crc16 / tx_send_crc16  out  1/8/1/1  drive the transmitter's transmit, data, update_crc16, send_crc16.
REQ-015 tx_data_strobe, tx_en  in  1/1  transmitter byte-consumed strobe and line-enable.

Function
REQ-016 States: IDLE, GAP, PID, DATA, END; encoding and PID constants come from the shared package.
REQ-017 IDLE: when tx_en low and hs_req or dat_req high, grant and enter PID; hs_req wins on a simultaneous request; dat_req stays pending.
REQ-018 At grant, latch kind (hs/dat), PID nibble p (ACK 0010, NAK 1010, STALL 1110, DATA0 0011, DATA1 1011), and zlp.
REQ-019 PID: tx_transmit=1, tx_data={~p,p}, tx_update_crc16=0; tx_send_crc16=1 iff data kind.
REQ-020 PID on tx_data_strobe: handshake or zlp -> END; else -> DATA.
REQ-021 DATA: tx_transmit=dat_valid, tx_data=dat_data, tx_update_crc16=1, tx_send_crc16=1; dat_ready=tx_data_strobe.
REQ-022 DATA on tx_data_strobe with dat_last=1 -> END.
REQ-023 DATA with dat_valid low: no dat_ready; the transmitter ends the packet with CRC; detected by tx_en falling -> GAP with dat_done (truncated packet).
REQ-024 END: tx_transmit=0, tx_send_crc16 held at the data-kind value; on tx_en falling (1 then 0) -> GAP and pulse hs_done or dat_done matching kind.
REQ-025 GAP: 8-bit counter loaded with IPG_CLKS on entry and decremented per cycle; -> IDLE when it reaches 0; requests are ignored until then.
REQ-026 Outside PID/DATA: tx_transmit=0, tx_data=0, tx_update_crc16=0.
REQ-027 A request dropped after grant does not abort the packet; the done pulse is still issued.
REQ-028 hs_done and dat_done are never high in the same cycle; at most one per packet.

Reset
REQ-029 rst_n low: state IDLE, counter 0, latched kind/PID/zlp 0, all outputs 0, asynchronously.
REQ-030 Reset mid-packet abandons the packet: no done pulse after release; the next grant requires tx_en low.

Structure
REQ-031 Shared package usb_pkg: PID nibble constants, hs_pid code constants, state typedef.
REQ-032 No sub-module; the gap counter is inline.
REQ-033 Single clock clk_48; all state registers use asynchronous active-low reset.

Verification
REQ-034 hs_req=1, hs_pid=0 -> one tx_data_strobe consumes 0xD2; tx_send_crc16=0; hs_done 1 cycle after tx_en falls.
REQ-035 dat_req, toggle=1, 3 bytes 0x01,0x02,0x03 (last on 0x03) -> bytes 0x4B,0x01,0x02,0x03; 3 dat_ready pulses; tx_send_crc16=1; dat_done.
REQ-036 hs_req and dat_req rise same cycle -> handshake sent first; data PID starts no earlier than IPG_CLKS after tx_en falls.
REQ-037 dat_zlp=1, toggle=0 -> only 0xC3 consumed, no dat_ready, tx_send_crc16=1, dat_done.
REQ-038 dat_valid dropped after byte 2 of 4 -> tx_transmit=0, packet ends, dat_done pulses, state GAP then IDLE.
REQ-039 rst_n asserted in DATA -> all outputs 0 at once; no done pulse; a fresh request after release is granted normally.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB transmit definitions: PID nibbles, handshake select codes, scheduler states.
package usb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GAP  = 3'd1,
        ST_PID  = 3'd2,
        ST_DATA = 3'd3,
        ST_END  = 3'd4
    } state_e;

    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    localparam logic [1:0] HS_ACK   = 2'd0;
    localparam logic [1:0] HS_NAK   = 2'd1;
    localparam logic [1:0] HS_STALL = 2'd2;
    localparam logic [1:0] HS_RSVD  = 2'd3;

    // Reserved select code goes out as STALL so the host never sees a bogus PID.
    function automatic logic [3:0] hs_pid_nibble(input logic [1:0] sel);
        logic [3:0] p;
        unique case (sel)
            HS_ACK:   p = PID_ACK;
            HS_NAK:   p = PID_NAK;
            HS_STALL: p = PID_STALL;
            HS_RSVD:  p = PID_STALL;
        endcase
        return p;
    endfunction

    function automatic logic [7:0] pid_byte(input logic [3:0] p);
        return {~p, p};
    endfunction

endpackage

// File: rtl/usb_tx_sched_if.sv
// Request/payload/transmitter bundle between packet sources and the USB TX scheduler.
interface usb_tx_sched_if;
    logic       hs_req;
    logic [1:0] hs_pid;
    logic       hs_done;
    logic       dat_req;
    logic       dat_toggle;
    logic       dat_zlp;
    logic       dat_valid;
    logic [7:0] dat_data;
    logic       dat_last;
    logic       dat_ready;
    logic       dat_done;
    logic       busy;
    logic       tx_transmit;
    logic [7:0] tx_data;
    logic       tx_update_crc16;
    logic       tx_send_crc16;
    logic       tx_data_strobe;
    logic       tx_en;

    modport master (
        output hs_req, hs_pid, dat_req, dat_toggle, dat_zlp,
               dat_valid, dat_data, dat_last, tx_data_strobe, tx_en,
        input  hs_done, dat_ready, dat_done, busy,
               tx_transmit, tx_data, tx_update_crc16, tx_send_crc16
    );

    modport slave (
        input  hs_req, hs_pid, dat_req, dat_toggle, dat_zlp,
               dat_valid, dat_data, dat_last, tx_data_strobe, tx_en,
        output hs_done, dat_ready, dat_done, busy,
               tx_transmit, tx_data, tx_update_crc16, tx_send_crc16
    );
endinterface

// File: rtl/usb_tx_sched.sv
// Arbitrates handshake vs data packets onto the USB transmitter and enforces an inter-packet gap.
// Latency: PID presented the cycle after grant; done pulses one cycle after tx_en falls.
// Backpressure: bytes advance only on tx_data_strobe; requests wait in IDLE while tx_en is high or during GAP.
module usb_tx_sched
    import usb_pkg::*;
#(
    parameter int unsigned IPG_CLKS = 16
) (
    input  logic           clk_48,
    input  logic           rst_n,
    usb_tx_sched_if.slave  bus
);

    localparam logic [7:0] IPG_LOAD = 8'(IPG_CLKS);

    state_e     state_q, state_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic       kind_dat_q, kind_dat_d;
    logic [3:0] pid_q, pid_d;
    logic       zlp_q, zlp_d;
    logic       tx_en_q, tx_en_d;
    logic       hs_done_q, hs_done_d;
    logic       dat_done_q, dat_done_d;

    logic       tx_fall;
    logic       transmit_c, update_c, send_c, ready_c;
    logic [7:0] data_c;

    assign tx_fall = tx_en_q & ~bus.tx_en;

    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        kind_dat_d = kind_dat_q;
        pid_d      = pid_q;
        zlp_d      = zlp_q;
        tx_en_d    = bus.tx_en;
        hs_done_d  = 1'b0;
        dat_done_d = 1'b0;
        transmit_c = 1'b0;
        data_c     = 8'h00;
        update_c   = 1'b0;
        send_c     = 1'b0;
        ready_c    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Handshake wins a tie; a pending data request is simply served later.
                if (!bus.tx_en && (bus.hs_req || bus.dat_req)) begin
                    state_d = ST_PID;
                    if (bus.hs_req) begin
                        kind_dat_d = 1'b0;
                        pid_d      = hs_pid_nibble(bus.hs_pid);
                        zlp_d      = 1'b0;
                    end else begin
                        kind_dat_d = 1'b1;
                        pid_d      = bus.dat_toggle ? PID_DATA1 : PID_DATA0;
                        zlp_d      = bus.dat_zlp;
                    end
                end
            end
            ST_PID: begin
                transmit_c = 1'b1;
                data_c     = pid_byte(pid_q);
                send_c     = kind_dat_q;
                if (bus.tx_data_strobe) begin
                    state_d = (!kind_dat_q || zlp_q) ? ST_END : ST_DATA;
                end
            end
            ST_DATA: begin
                transmit_c = bus.dat_valid;
                data_c     = bus.dat_data;
                update_c   = 1'b1;
                send_c     = 1'b1;
                ready_c    = bus.tx_data_strobe & bus.dat_valid;
                // Starved payload: the transmitter closes the packet with CRC on its own.
                if (tx_fall) begin
                    state_d    = ST_GAP;
                    gap_cnt_d  = IPG_LOAD;
                    dat_done_d = 1'b1;
                end else if (ready_c && bus.dat_last) begin
                    state_d = ST_END;
                end
            end
            ST_END: begin
                send_c = kind_dat_q;
                if (tx_fall) begin
                    state_d    = ST_GAP;
                    gap_cnt_d  = IPG_LOAD;
                    hs_done_d  = ~kind_dat_q;
                    dat_done_d = kind_dat_q;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q <= 8'd1) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = 8'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gap_cnt_q  <= 8'd0;
            kind_dat_q <= 1'b0;
            pid_q      <= 4'd0;
            zlp_q      <= 1'b0;
            tx_en_q    <= 1'b0;
            hs_done_q  <= 1'b0;
            dat_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            kind_dat_q <= kind_dat_d;
            pid_q      <= pid_d;
            zlp_q      <= zlp_d;
            tx_en_q    <= tx_en_d;
            hs_done_q  <= hs_done_d;
            dat_done_q <= dat_done_d;
        end
    end

    assign bus.busy            = (state_q != ST_IDLE);
    assign bus.hs_done         = hs_done_q;
    assign bus.dat_done        = dat_done_q;
    assign bus.dat_ready       = ready_c;
    assign bus.tx_transmit     = transmit_c;
    assign bus.tx_data         = data_c;
    assign bus.tx_update_crc16 = update_c;
    assign bus.tx_send_crc16   = send_c;

endmodule

// File: tb/tb_usb_tx_sched.sv
// Directed bench for usb_tx_sched; the transmitter is emulated by hand-driven tx_en/tx_data_strobe.
module tb_usb_tx_sched;

    localparam int IPG = 16;

    logic clk_48 = 1'b0;
    logic rst_n  = 1'b0;
    int   errors = 0;
    int   checks = 0;

    usb_tx_sched_if bus ();

    usb_tx_sched #(.IPG_CLKS(IPG)) dut (
        .clk_48 (clk_48),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #10 clk_48 = ~clk_48;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk_48);
        #1;
    endtask

    // Counts remaining cycles with busy high, bounded so a stuck FSM cannot hang the run.
    task automatic count_busy(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 400) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        bus.hs_req = 0; bus.hs_pid = 0; bus.dat_req = 0; bus.dat_toggle = 0;
        bus.dat_zlp = 0; bus.dat_valid = 0; bus.dat_data = 0; bus.dat_last = 0;
        bus.tx_data_strobe = 0; bus.tx_en = 0;
        rst_n = 0;
        #5;
        checks++;
        if ({bus.busy, bus.hs_done, bus.dat_done, bus.dat_ready, bus.tx_transmit,
             bus.tx_update_crc16, bus.tx_send_crc16} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000000", {bus.busy, bus.hs_done, bus.dat_done,
                     bus.dat_ready, bus.tx_transmit, bus.tx_update_crc16, bus.tx_send_crc16});
        end
        checks++;
        if (bus.tx_data !== 8'h00) begin
            errors++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data);
        end
        repeat (2) @(negedge clk_48);
        rst_n = 1;
        step();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_release_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_handshake();
        int n;
        bus.hs_req = 1; bus.hs_pid = 2'd0;
        step();
        checks++;
        if ({bus.busy, bus.tx_transmit, bus.tx_update_crc16, bus.tx_send_crc16} !== 4'b1100) begin
            errors++; $display("FAIL ack_pid_ctrl: got %b want 1100",
                     {bus.busy, bus.tx_transmit, bus.tx_update_crc16, bus.tx_send_crc16});
        end
        checks++;
        if (bus.tx_data !== 8'hD2) begin
            errors++; $display("FAIL ack_pid_byte: got %h want d2", bus.tx_data);
        end
        bus.tx_en = 1; bus.tx_data_strobe = 1;
        step();
        bus.tx_data_strobe = 0;
        #1;
        checks++;
        if ({bus.busy, bus.tx_transmit, bus.tx_send_crc16, bus.hs_done} !== 4'b1000) begin
            errors++; $display("FAIL ack_end: got %b want 1000",
                     {bus.busy, bus.tx_transmit, bus.tx_send_crc16, bus.hs_done});
        end
        bus.tx_en = 0;
        step();
        checks++;
        if ({bus.hs_done, bus.dat_done} !== 2'b10) begin
            errors++; $display("FAIL ack_done: got %b want 10", {bus.hs_done, bus.dat_done});
        end
        bus.hs_req = 0;
        step();
        checks++;
        if ({bus.hs_done, bus.dat_done} !== 2'b00) begin
            errors++; $display("FAIL ack_done_width: got %b want 00", {bus.hs_done, bus.dat_done});
        end
        // GAP lasts IPG cycles; the done-pulse cycle was the first of them.
        count_busy(n);
        checks++;
        if (n !== IPG - 1) begin
            errors++; $display("FAIL ack_gap_len: got %0d want %0d", n, IPG - 1);
        end
    endtask

    task automatic test_data_packet();
        logic [7:0] bytes [3] = '{8'h01, 8'h02, 8'h03};
        int ready_cnt = 0;
        int n;
        bus.dat_req = 1; bus.dat_toggle = 1; bus.dat_zlp = 0;
        bus.dat_valid = 1; bus.dat_data = 8'h01; bus.dat_last = 0;
        step();
        checks++;
        if (bus.tx_data !== 8'h4B) begin
            errors++; $display("FAIL data1_pid_byte: got %h want 4b", bus.tx_data);
        end
        checks++;
        if ({bus.tx_transmit, bus.tx_update_crc16, bus.tx_send_crc16, bus.dat_ready} !== 4'b1010) begin
            errors++; $display("FAIL data1_pid_ctrl: got %b want 1010",
                     {bus.tx_transmit, bus.tx_update_crc16, bus.tx_send_crc16, bus.dat_ready});
        end
        bus.tx_en = 1; bus.tx_data_strobe = 1;
        #1;
        checks++;
        if (bus.dat_ready !== 1'b0) begin
            errors++; $display("FAIL data1_pid_no_ready: got %b want 0", bus.dat_ready);
        end
        step();
        for (int i = 0; i < 3; i++) begin
            bus.dat_data = bytes[i]; bus.dat_last = (i == 2); bus.tx_data_strobe = 0;
            #1;
            checks++;
            if ({bus.tx_transmit, bus.tx_update_crc16, bus.tx_send_crc16} !== 3'b111
                || bus.tx_data !== bytes[i]) begin
                errors++; $display("FAIL data1_byte%0d: got ctrl %b data %h want 111 %h", i,
                         {bus.tx_transmit, bus.tx_update_crc16, bus.tx_send_crc16}, bus.tx_data, bytes[i]);
            end
            ready_cnt += int'(bus.dat_ready);
            step();
            bus.tx_data_strobe = 1;
            #1;
            ready_cnt += int'(bus.dat_ready);
            step();
        end
        bus.tx_data_strobe = 0; bus.dat_valid = 0; bus.dat_last = 0;
        #1;
        checks++;
        if (ready_cnt !== 3) begin
            errors++; $display("FAIL data1_ready_count: got %0d want 3", ready_cnt);
        end
        checks++;
        if ({bus.busy, bus.tx_transmit, bus.tx_update_crc16, bus.tx_send_crc16} !== 4'b1001
            || bus.tx_data !== 8'h00) begin
            errors++; $display("FAIL data1_end: got ctrl %b data %h want 1001 00",
                     {bus.busy, bus.tx_transmit, bus.tx_update_crc16, bus.tx_send_crc16}, bus.tx_data);
        end
        step();
        step();
        bus.tx_en = 0;
        step();
        checks++;
        if ({bus.hs_done, bus.dat_done} !== 2'b01) begin
            errors++; $display("FAIL data1_done: got %b want 01", {bus.hs_done, bus.dat_done});
        end
        bus.dat_req = 0;
        step();
        count_busy(n);
        checks++;
        if (n !== IPG - 1) begin
            errors++; $display("FAIL data1_gap_len: got %0d want %0d", n, IPG - 1);
        end
    endtask

    // Simultaneous requests: NAK first, then a DATA0 zero-length packet after the gap.
    task automatic test_priority_zlp();
        int n;
        bus.hs_req = 1; bus.hs_pid = 2'd1;
        bus.dat_req = 1; bus.dat_toggle = 0; bus.dat_zlp = 1; bus.dat_valid = 0;
        step();
        checks++;
        if (bus.tx_data !== 8'h5A || bus.tx_send_crc16 !== 1'b0) begin
            errors++; $display("FAIL prio_first_pid: got %h crc %b want 5a 0",
                     bus.tx_data, bus.tx_send_crc16);
        end
        bus.tx_en = 1; bus.tx_data_strobe = 1;
        step();
        bus.tx_data_strobe = 0; bus.tx_en = 0;
        step();
        checks++;
        if ({bus.hs_done, bus.dat_done} !== 2'b10) begin
            errors++; $display("FAIL prio_hs_done: got %b want 10", {bus.hs_done, bus.dat_done});
        end
        bus.hs_req = 0;
        // One cycle to see tx_en fall, IPG gap cycles, one IDLE cycle to grant.
        n = 1;
        while (bus.tx_transmit !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (n !== IPG + 2) begin
            errors++; $display("FAIL prio_gap_to_data_pid: got %0d want %0d", n, IPG + 2);
        end
        checks++;
        if (bus.tx_data !== 8'hC3 || bus.tx_send_crc16 !== 1'b1 || bus.tx_update_crc16 !== 1'b0) begin
            errors++; $display("FAIL zlp_pid: got %h crc %b upd %b want c3 1 0",
                     bus.tx_data, bus.tx_send_crc16, bus.tx_update_crc16);
        end
        bus.tx_en = 1; bus.tx_data_strobe = 1;
        #1;
        checks++;
        if (bus.dat_ready !== 1'b0) begin
            errors++; $display("FAIL zlp_no_ready: got %b want 0", bus.dat_ready);
        end
        step();
        bus.tx_data_strobe = 0;
        #1;
        checks++;
        if ({bus.busy, bus.tx_transmit, bus.tx_update_crc16, bus.tx_send_crc16, bus.dat_ready} !== 5'b10010) begin
            errors++; $display("FAIL zlp_end: got %b want 10010", {bus.busy, bus.tx_transmit,
                     bus.tx_update_crc16, bus.tx_send_crc16, bus.dat_ready});
        end
        step();
        bus.tx_en = 0;
        step();
        checks++;
        if ({bus.hs_done, bus.dat_done} !== 2'b01) begin
            errors++; $display("FAIL zlp_done: got %b want 01", {bus.hs_done, bus.dat_done});
        end
        bus.dat_req = 0; bus.dat_zlp = 0;
        step();
        count_busy(n);
        checks++;
        if (n !== IPG - 1) begin
            errors++; $display("FAIL zlp_gap_len: got %0d want %0d", n, IPG - 1);
        end
    endtask

    task automatic test_truncate();
        logic [7:0] bytes [2] = '{8'hAA, 8'hBB};
        int n;
        bus.dat_req = 1; bus.dat_toggle = 0; bus.dat_zlp = 0;
        bus.dat_valid = 1; bus.dat_data = 8'hAA; bus.dat_last = 0;
        step();
        bus.tx_en = 1; bus.tx_data_strobe = 1;
        step();
        for (int i = 0; i < 2; i++) begin
            bus.dat_data = bytes[i]; bus.tx_data_strobe = 0;
            step();
            bus.tx_data_strobe = 1;
            #1;
            checks++;
            if (bus.dat_ready !== 1'b1 || bus.tx_data !== bytes[i]) begin
                errors++; $display("FAIL trunc_byte%0d: got ready %b data %h want 1 %h",
                         i, bus.dat_ready, bus.tx_data, bytes[i]);
            end
            step();
        end
        bus.dat_valid = 0; bus.tx_data_strobe = 0;
        #1;
        checks++;
        if ({bus.busy, bus.tx_transmit, bus.tx_update_crc16, bus.dat_ready} !== 4'b1010) begin
            errors++; $display("FAIL trunc_starved: got %b want 1010",
                     {bus.busy, bus.tx_transmit, bus.tx_update_crc16, bus.dat_ready});
        end
        step();
        step();
        bus.tx_en = 0;
        step();
        checks++;
        if ({bus.busy, bus.hs_done, bus.dat_done, bus.tx_transmit, bus.tx_update_crc16} !== 5'b10100) begin
            errors++; $display("FAIL trunc_done: got %b want 10100",
                     {bus.busy, bus.hs_done, bus.dat_done, bus.tx_transmit, bus.tx_update_crc16});
        end
        bus.dat_req = 0;
        step();
        count_busy(n);
        checks++;
        if (n !== IPG - 1) begin
            errors++; $display("FAIL trunc_gap_len: got %0d want %0d", n, IPG - 1);
        end
    endtask

    task automatic test_reset_mid_packet();
        int n;
        logic done_seen = 1'b0;
        logic busy_seen = 1'b0;
        bus.dat_req = 1; bus.dat_toggle = 1; bus.dat_zlp = 0;
        bus.dat_valid = 1; bus.dat_data = 8'h55; bus.dat_last = 0;
        step();
        bus.tx_en = 1; bus.tx_data_strobe = 1;
        step();
        checks++;
        if (bus.dat_ready !== 1'b1 || bus.tx_transmit !== 1'b1) begin
            errors++; $display("FAIL rst_pre_data: got ready %b tx %b want 1 1",
                     bus.dat_ready, bus.tx_transmit);
        end
        rst_n = 0;
        #1;
        checks++;
        if ({bus.busy, bus.tx_transmit, bus.dat_ready, bus.tx_update_crc16, bus.tx_send_crc16} !== 5'b0
            || bus.tx_data !== 8'h00) begin
            errors++; $display("FAIL rst_async_outputs: got ctrl %b data %h want 00000 00",
                     {bus.busy, bus.tx_transmit, bus.dat_ready, bus.tx_update_crc16, bus.tx_send_crc16},
                     bus.tx_data);
        end
        bus.tx_data_strobe = 0;
        step();
        rst_n = 1;
        // tx_en still high from the abandoned packet: no grant, no done pulse.
        for (int i = 0; i < 4; i++) begin
            step();
            done_seen |= bus.dat_done | bus.hs_done;
            busy_seen |= bus.busy;
        end
        checks++;
        if ({done_seen, busy_seen} !== 2'b00) begin
            errors++; $display("FAIL rst_no_done_no_grant: got %b want 00", {done_seen, busy_seen});
        end
        bus.dat_req = 0; bus.dat_valid = 0; bus.hs_req = 1; bus.hs_pid = 2'd3; bus.tx_en = 0;
        step();
        checks++;
        if (bus.tx_data !== 8'h1E || bus.tx_send_crc16 !== 1'b0) begin
            errors++; $display("FAIL rst_regrant_stall: got %h crc %b want 1e 0",
                     bus.tx_data, bus.tx_send_crc16);
        end
        bus.hs_req = 0;
        bus.tx_en = 1; bus.tx_data_strobe = 1;
        step();
        bus.tx_data_strobe = 0; bus.tx_en = 0;
        step();
        checks++;
        if ({bus.hs_done, bus.dat_done} !== 2'b10) begin
            errors++; $display("FAIL dropped_req_done: got %b want 10", {bus.hs_done, bus.dat_done});
        end
        step();
        count_busy(n);
        checks++;
        if (n !== IPG - 1) begin
            errors++; $display("FAIL rst_final_gap: got %0d want %0d", n, IPG - 1);
        end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_data_packet();
        test_priority_zlp();
        test_truncate();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
